// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
// Imported by serial_adder; no logic of its own.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must reach WIDTH-1 without wrapping.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// Single-bit combinational full adder, the arithmetic core of the serial adder.
// Zero latency; no flow control.
module full_adder_cell (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = x ^ y ^ cin;
   assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract, LSB first; result registers update WIDTH edges after start is accepted.
// start is ignored while busy; a start held during the done cycle is accepted back-to-back.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow
);

   state_t           state;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] work;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             fa_s;
   logic             fa_c;
   logic             last;

   full_adder_cell u_fa (
      .x    (opa[0]),
      .y    (opb[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   assign last = (cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         opa       <= '0;
         opb       <= '0;
         work      <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  // Subtraction is a + ~b + 1: invert b and seed the carry.
                  opa   <= a;
                  opb   <= sub ? ~b : b;
                  carry <= sub;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               work  <= {fa_s, work[WIDTH-1:1]};
               opa   <= {1'b0, opa[WIDTH-1:1]};
               opb   <= {1'b0, opb[WIDTH-1:1]};
               carry <= fa_c;
               cnt   <= cnt + CNT_W'(1);
               if (last) begin
                  // On the MSB step, carry still holds the carry into the MSB.
                  sum       <= {fa_s, work[WIDTH-1:1]};
                  carry_out <= fa_c;
                  overflow  <= carry ^ fa_c;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed cases plus random operations against an arithmetic model.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         carry_out;
   logic         overflow;

   int           total = 0;
   int           bad   = 0;
   logic [W-1:0] last_sum;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sub       (sub),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Returns {overflow, carry_out, sum} from plain integer arithmetic.
   function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
      int   ux, uy, sx, sy, u, r;
      logic co, ov;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (!s) begin
         u  = ux + uy;
         r  = sx + sy;
         co = (u >= (1 << W));
      end else begin
         u  = ux - uy;
         r  = sx - sy;
         co = (ux >= uy);
      end
      ov = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
      return {ov, co, W'(u)};
   endfunction

   // Present an operation and let the next edge accept it.
   task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      a     = x;
      b     = y;
      sub   = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
   endtask

   // Wait for done, checking latency, busy span, result hold and the result itself.
   task automatic finish_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic s, input int inject_at);
      logic [W+1:0] e;
      int           lat;
      int           bcnt;
      bit           seen;
      bit           hold_ok;
      e       = model(x, y, s);
      lat     = 0;
      bcnt    = busy ? 1 : 0;
      seen    = 1'b0;
      hold_ok = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) begin
            seen = 1'b1;
            lat  = k;
            break;
         end
         if (busy) bcnt++;
         if (sum !== last_sum) hold_ok = 1'b0;
         if (k == inject_at) begin
            a     = '1;
            start = 1'b1;
         end
      end
      if (!seen) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         chk({tag, "_latency"}, 32'(lat), 32'(W));
         chk({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
         chk({tag, "_cout"}, 32'(carry_out), 32'(e[W]));
         chk({tag, "_ovf"}, 32'(overflow), 32'(e[W+1]));
         chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
         chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(W));
         chk({tag, "_hold"}, 32'(hold_ok), 32'd1);
         last_sum = e[W-1:0];
      end
   endtask

   initial begin
      logic [W-1:0] rx, ry;
      logic         rs;
      int           cnt_act;

      rst      = 1'b1;
      start    = 1'b0;
      sub      = 1'b0;
      a        = '0;
      b        = '0;
      last_sum = '0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(carry_out), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      launch(8'h3C, 8'h5A, 1'b0);
      finish_op("add_ovf", 8'h3C, 8'h5A, 1'b0, 0);
      @(posedge clk);
      #1;
      chk("done_one_cycle", 32'(done), 32'd0);
      chk("result_held_idle", 32'(sum), 32'h96);

      launch(8'hFF, 8'h01, 1'b0);
      finish_op("add_wrap", 8'hFF, 8'h01, 1'b0, 0);
      @(posedge clk);
      #1;
      launch(8'h05, 8'h07, 1'b1);
      finish_op("sub_borrow", 8'h05, 8'h07, 1'b1, 0);
      @(posedge clk);
      #1;
      launch(8'h80, 8'h01, 1'b1);
      finish_op("sub_ovf", 8'h80, 8'h01, 1'b1, 0);
      @(posedge clk);
      #1;

      // Start pulse during RUN is ignored; start held in the done cycle chains.
      launch(8'h10, 8'h20, 1'b0);
      finish_op("b2b_first", 8'h10, 8'h20, 1'b0, 2);
      chk("b2b_first_value", 32'(sum), 32'h30);
      launch(8'h01, 8'h01, 1'b0);
      finish_op("b2b_second", 8'h01, 8'h01, 1'b0, 0);
      chk("b2b_second_value", 32'(sum), 32'h02);

      // Asynchronous reset in the 4th RUN cycle.
      @(posedge clk);
      #1;
      launch(8'h40, 8'h11, 1'b0);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_sum", 32'(sum), 32'd0);
      chk("mid_rst_cout", 32'(carry_out), 32'd0);
      chk("mid_rst_ovf", 32'(overflow), 32'd0);
      #1;
      rst      = 1'b0;
      last_sum = '0;
      cnt_act  = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (done || busy) cnt_act++;
      end
      chk("post_rst_quiet", 32'(cnt_act), 32'd0);
      launch(8'h01, 8'h02, 1'b0);
      finish_op("post_rst_add", 8'h01, 8'h02, 1'b0, 0);

      repeat (40) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         rx = W'($urandom);
         ry = W'($urandom);
         rs = 1'($urandom);
         launch(rx, ry, rs);
         finish_op("rand", rx, ry, rs, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
